// File: rtl/uart_pkg.sv
// Shared UART transmitter types: FSM state encoding, frame bit counts and the
// holding-register payload captured on acceptance.
package uart_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;
  localparam int unsigned BAUD_CNT_W           = 16;

  localparam int unsigned START_BITS  = 1;
  localparam int unsigned STOP_BITS   = 1;
  localparam int unsigned DATA_BITS_8 = 8;
  localparam int unsigned DATA_BITS_7 = 7;
  localparam int unsigned BIT_IDX_W   = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       eight;
    logic       pen;
    logic       ohel;
  } tx_req_t;

  // Index of the final data bit for the selected frame size.
  function automatic logic [BIT_IDX_W-1:0] last_data_idx(input logic eight);
    return eight ? BIT_IDX_W'(DATA_BITS_8 - 1) : BIT_IDX_W'(DATA_BITS_7 - 1);
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Host-side load handshake and serial line of the UART transmitter.
interface uart_tx_if;

  logic       tx_start;
  logic [7:0] tx_data;
  logic       eight;
  logic       pen;
  logic       ohel;
  logic       tx;
  logic       tx_rdy;
  logic       tx_busy;

  modport master (
    output tx_start,
    output tx_data,
    output eight,
    output pen,
    output ohel,
    input  tx,
    input  tx_rdy,
    input  tx_busy
  );

  modport slave (
    input  tx_start,
    input  tx_data,
    input  eight,
    input  pen,
    input  ohel,
    output tx,
    output tx_rdy,
    output tx_busy
  );

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts CLKS_PER_BIT cycles per serial bit and raises a
// registered bit_done_o during the final cycle of every bit while running.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic run_i,
  output logic bit_done_o
);

  localparam int unsigned CNT_W = BAUD_CNT_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  // Reload at each bit boundary, on a fresh start, and whenever the line idles.
  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    done_d = 1'b0;
    if (clear_i || !run_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
    done_d = run_i && (cnt_d == LAST);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign bit_done_o = done_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one-deep holding register feeding a frame FSM and shift
// register. Build with UART_TX_PARITY_EN to enable the optional parity bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic     clk,
  input  logic     reset,
  uart_tx_if.slave bus
);

  tx_state_e              state_q, state_d;
  tx_req_t                hold_q, hold_d;
  logic                   tx_rdy_q, tx_rdy_d;
  logic [7:0]             shift_q, shift_d;
  logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic                   fr_eight_q, fr_eight_d;
  logic                   fr_par_en_q, fr_par_en_d;
  logic                   fr_par_bit_q, fr_par_bit_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;

  logic                   bit_done;
  logic                   accept_c;
  logic                   load_c;
  logic                   load_par_en_c;
  logic                   load_par_bit_c;

`ifdef UART_TX_PARITY_EN
  logic [7:0]             load_bits_c;

  // Parity covers only the bits actually sent; bit 7 is excluded for 7-bit frames.
  assign load_bits_c    = hold_q.eight ? hold_q.data : {1'b0, hold_q.data[6:0]};
  assign load_par_en_c  = hold_q.pen;
  assign load_par_bit_c = (^load_bits_c) ^ hold_q.ohel;
`else
  logic                   unused_par_c;

  assign load_par_en_c  = 1'b0;
  assign load_par_bit_c = 1'b0;
  assign unused_par_c   = hold_q.pen ^ hold_q.ohel;
`endif

  assign accept_c = bus.tx_start && tx_rdy_q;

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (state_q == ST_IDLE),
    .run_i      (state_d != ST_IDLE),
    .bit_done_o (bit_done)
  );

  // Next-state, holding/shift register updates and registered line outputs.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    tx_rdy_d     = tx_rdy_q;
    shift_d      = shift_q;
    bit_idx_d    = bit_idx_q;
    fr_eight_d   = fr_eight_q;
    fr_par_en_d  = fr_par_en_q;
    fr_par_bit_d = fr_par_bit_q;
    tx_d         = 1'b1;
    busy_d       = 1'b0;
    load_c       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!tx_rdy_q) begin
          load_c = 1'b1;
        end
      end
      ST_START: begin
        if (bit_done) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          if (bit_idx_q == last_data_idx(fr_eight_q)) begin
            state_d = fr_par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          if (!tx_rdy_q) begin
            load_c = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A transfer needs a full holding register, acceptance an empty one.
    if (load_c) begin
      state_d      = ST_START;
      shift_d      = hold_q.data;
      bit_idx_d    = '0;
      fr_eight_d   = hold_q.eight;
      fr_par_en_d  = load_par_en_c;
      fr_par_bit_d = load_par_bit_c;
      tx_rdy_d     = 1'b1;
    end else if (accept_c) begin
      hold_d.data  = bus.tx_data;
      hold_d.eight = bus.eight;
      hold_d.pen   = bus.pen;
      hold_d.ohel  = bus.ohel;
      tx_rdy_d     = 1'b0;
    end

    unique case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = fr_par_bit_d;
      default:   tx_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      tx_rdy_q     <= 1'b1;
      shift_q      <= '0;
      bit_idx_q    <= '0;
      fr_eight_q   <= 1'b0;
      fr_par_en_q  <= 1'b0;
      fr_par_bit_q <= 1'b0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      tx_rdy_q     <= tx_rdy_d;
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      fr_eight_q   <= fr_eight_d;
      fr_par_en_q  <= fr_par_en_d;
      fr_par_bit_q <= fr_par_bit_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.tx      = tx_q;
  assign bus.tx_rdy  = tx_rdy_q;
  assign bus.tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a queue-based line model predicts tx/tx_rdy/tx_busy every
// cycle, plus directed frame checks and a randomized traffic phase.
module tb_uart_tx;

  localparam int unsigned N = 4;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif

  logic clk;
  logic reset;

  uart_tx_if bus ();

  uart_tx #(
    .CLKS_PER_BIT (N)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int bcnt     = 0;
  bit line_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: expected line values per cycle, held as an expanded bit list.
  bit exp_line[$];
  bit pend_bits[$];
  bit pend  = 1'b0;
  bit m_rdy = 1'b1;
  bit m_tx  = 1'b1;
  bit m_busy = 1'b0;
  bit m_on  = 1'b0;

  always @(posedge clk) begin
    bit rdy_before;
    bit p;
    int nb;
    m_on = 1'b1;
    if (reset !== 1'b1) begin
      exp_line.delete();
      pend_bits.delete();
      pend   = 1'b0;
      m_rdy  = 1'b1;
      m_tx   = 1'b1;
      m_busy = 1'b0;
    end else begin
      rdy_before = m_rdy;
      if (exp_line.size() == 0 && pend) begin
        foreach (pend_bits[k]) begin
          for (int c = 0; c < int'(N); c++) exp_line.push_back(pend_bits[k]);
        end
        pend  = 1'b0;
        m_rdy = 1'b1;
      end
      if (exp_line.size() != 0) begin
        m_tx   = exp_line.pop_front();
        m_busy = 1'b1;
      end else begin
        m_tx   = 1'b1;
        m_busy = 1'b0;
      end
      if (bus.tx_start === 1'b1 && rdy_before) begin
        pend_bits.delete();
        pend_bits.push_back(1'b0);
        nb = (bus.eight === 1'b1) ? 8 : 7;
        p  = 1'b0;
        for (int i = 0; i < nb; i++) begin
          pend_bits.push_back(bus.tx_data[i]);
          p = p ^ bus.tx_data[i];
        end
        if (PAR_BUILD && bus.pen === 1'b1) pend_bits.push_back(p ^ bus.ohel);
        pend_bits.push_back(1'b1);
        pend  = 1'b1;
        m_rdy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      check("line_tx",   32'(bus.tx),      32'(m_tx));
      check("line_rdy",  32'(bus.tx_rdy),  32'(m_rdy));
      check("line_busy", 32'(bus.tx_busy), 32'(m_busy));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    if (bus.tx_busy === 1'b1) begin
      bcnt++;
      line_q.push_back(bus.tx);
    end
  endtask

  // Pulse tx_start for one cycle, then scramble the config lines.
  task automatic send(input logic [7:0] d, input logic e, input logic p, input logic o);
    bus.tx_start = 1'b1;
    bus.tx_data  = d;
    bus.eight    = e;
    bus.pen      = p;
    bus.ohel     = o;
    step();
    bus.tx_start = 1'b0;
    bus.tx_data  = 8'($urandom);
    bus.eight    = 1'($urandom_range(0, 1));
    bus.pen      = 1'($urandom_range(0, 1));
    bus.ohel     = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 300; i++) begin
      step();
      if (bus.tx_busy === 1'b0 && bus.tx_rdy === 1'b1) break;
    end
    check(tag, 32'({bus.tx_busy, bus.tx_rdy}), 32'(2'b01));
  endtask

  task automatic wait_rdy(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (bus.tx_rdy === 1'b1) break;
      step();
    end
    check(tag, 32'(bus.tx_rdy), 32'(1));
  endtask

  task automatic frame(input string tag, input logic [7:0] d, input logic e,
                       input logic p, input logic o, input int exp_len);
    bcnt = 0;
    line_q.delete();
    send(d, e, p, o);
    wait_done({tag, "_done"});
    check({tag, "_len"}, 32'(bcnt), 32'(exp_len));
  endtask

  initial begin
    logic [9:0] a5_frame;
    bit par_exp;
    reset        = 1'b0;
    bus.tx_start = 1'b0;
    bus.tx_data  = 8'h00;
    bus.eight    = 1'b1;
    bus.pen      = 1'b0;
    bus.ohel     = 1'b0;
    repeat (3) step();
    check("rst_tx",   32'(bus.tx),      32'(1));
    check("rst_rdy",  32'(bus.tx_rdy),  32'(1));
    check("rst_busy", 32'(bus.tx_busy), 32'(0));
    reset = 1'b1;
    step();

    // 8N1 0xA5: exact bit pattern and 40-cycle frame.
    frame("a5", 8'hA5, 1'b1, 1'b0, 1'b0, 40);
    a5_frame = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10; k++)
      check($sformatf("a5_bit%0d", k), 32'(line_q[k*N + N/2]), 32'(a5_frame[k]));

    // 0x41 with parity: even then odd sense.
    frame("p_even", 8'h41, 1'b1, 1'b1, 1'b0, PAR_BUILD ? 44 : 40);
    par_exp = PAR_BUILD ? 1'b0 : 1'b1;
    check("p_even_bit", 32'(line_q[9*N + N/2]), 32'(par_exp));
    frame("p_odd", 8'h41, 1'b1, 1'b1, 1'b1, PAR_BUILD ? 44 : 40);
    check("p_odd_bit", 32'(line_q[9*N + N/2]), 32'(1));

    // 7-bit frame drops bit 7.
    frame("seven", 8'hFF, 1'b0, 1'b0, 1'b0, 36);

    // Back-to-back frames, third request while full is ignored.
    bcnt = 0;
    line_q.delete();
    send(8'h5A, 1'b1, 1'b0, 1'b0);
    wait_rdy("b2b_rdy");
    send(8'h96, 1'b1, 1'b0, 1'b0);
    check("b2b_full", 32'(bus.tx_rdy), 32'(0));
    send(8'h00, 1'b1, 1'b1, 1'b1);
    wait_done("b2b_done");
    check("b2b_len", 32'(bcnt), 32'(80));
    check("b2b_start2", 32'(line_q[10*N + N/2]), 32'(0));
    repeat (30) step();
    check("b2b_no_third", 32'(bcnt), 32'(80));

    // Reset during data bit 3 with a byte pending.
    bcnt = 0;
    send(8'h3C, 1'b1, 1'b0, 1'b0);
    wait_rdy("rs_rdy");
    send(8'hC3, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      if (bcnt >= 18) break;
      step();
    end
    check("rs_in_bit3", 32'(bcnt), 32'(18));
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("rs_tx",   32'(bus.tx),      32'(1));
    check("rs_rdy",  32'(bus.tx_rdy),  32'(1));
    check("rs_busy", 32'(bus.tx_busy), 32'(0));
    bcnt = 0;
    repeat (60) step();
    check("rs_no_pending", 32'(bcnt), 32'(0));

    // Randomized traffic against the line model.
    for (int i = 0; i < 1500; i++) begin
      bus.tx_start = ($urandom_range(0, 5) == 0);
      bus.tx_data  = 8'($urandom);
      bus.eight    = 1'($urandom_range(0, 1));
      bus.pen      = 1'($urandom_range(0, 1));
      bus.ohel     = 1'($urandom_range(0, 1));
      reset        = ($urandom_range(0, 399) != 0);
      step();
    end
    bus.tx_start = 1'b0;
    reset        = 1'b1;
    step();
    wait_done("rand_drain");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per serial bit (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all logic is rising-edge triggered.
REQ-003 The block SHALL have port reset, input, 1, reset that is synchronous and active-low.
REQ-004 The block SHALL have port tx_start, input, 1, load request; accepted only when tx_rdy=1.
REQ-005 The block SHALL have port tx_data, input, 8, byte to send; sampled on acceptance.
REQ-006 The block SHALL have port eight, input, 1, frame size select: 1 = 8 data bits, 0 = 7 data bits (tx_data[7] ignored).
REQ-007 The block SHALL have port pen, input, 1, parity enable.
REQ-008 The block SHALL have port ohel, input, 1, parity sense: 1 = odd, 0 = even.
REQ-009 The block SHALL have port tx, output, 1, serial line; idles high.
REQ-010 The block SHALL have port tx_rdy, output, 1, high when the holding register is empty.
REQ-011 The block SHALL have port tx_busy, output, 1, high while a frame is on the line.

Function
REQ-012 Acceptance: on a clk edge with tx_start=1 and tx_rdy=1, tx_data, eight, pen and ohel SHALL be captured into the holding register and tx_rdy SHALL fall in the next cycle.
REQ-013 tx_start with tx_rdy=0 SHALL be ignored; no data SHALL be lost or overwritten.
REQ-014 Holding register SHALL transfer to the shift register in the first cycle the FSM is in IDLE with the holding register full; tx_rdy SHALL rise in the cycle after the transfer.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; IDLE->START on transfer, START->DATA, DATA->PARITY when last data bit ends and parity is active, DATA->STOP otherwise, PARITY->STOP, STOP->IDLE, or STOP->START directly when the holding register is full.
REQ-016 tx SHALL go low exactly one cycle after the transfer; each bit SHALL be held exactly CLKS_PER_BIT cycles by a baud counter that reloads at each bit boundary.
REQ-017 Data SHALL be sent LSB first; 7 or 8 bits per captured eight.
REQ-018 Parity bit SHALL be the XOR of the sent data bits, inverted when ohel=1.
REQ-019 Stop SHALL be one bit, tx=1; back-to-back frames SHALL have no idle gap beyond the stop bit.
REQ-020 tx_busy SHALL be high from the cycle tx goes low for START until the end of STOP with no pending frame.
REQ-021 Changes to eight, pen, ohel after acceptance SHALL NOT affect the frame already captured.

Reset
REQ-022 With reset=0 at a clk edge: FSM=IDLE, counters=0, holding empty, tx=1, tx_rdy=1, tx_busy=0 from the next cycle.
REQ-023 Reset asserted mid-frame SHALL abort the frame and drive tx=1 in the next cycle; the pending holding byte SHALL be discarded.
REQ-024 tx_start concurrent with reset=0 SHALL be ignored.

Configuration
REQ-025 With macro UART_TX_PARITY_EN defined, the PARITY state and pen/ohel behaviour SHALL be as above.
REQ-026 Without UART_TX_PARITY_EN, pen and ohel SHALL remain as ports but be ignored, PARITY SHALL be unreachable, and frames SHALL be start+data+stop only.

Structure
REQ-027 A shared package uart_pkg SHALL hold the FSM state encoding, DEFAULT_CLKS_PER_BIT and frame bit-count constants.
REQ-028 Baud timing SHALL be a sub-module uart_baud_cnt (counter with reload, bit_done pulse); the FSM, holding and shift registers SHALL be in uart_tx.

Verification (CLKS_PER_BIT=4)
REQ-029 Reset, then tx_data=8'hA5, eight=1, pen=0 -> tx: 0, 1,0,1,0,0,1,0,1, 1, each 4 cycles; tx low one cycle after transfer; tx_busy high 40 cycles.
REQ-030 tx_data=8'h41, eight=1, pen=1, ohel=0 -> parity bit 0; same with ohel=1 -> parity bit 1; frame 44 cycles (macro defined); undefined macro -> 40 cycles, no parity bit.
REQ-031 eight=0, tx_data=8'hFF -> 7 data ones, bit 7 absent, frame 36 cycles.
REQ-032 Two tx_start pulses, second issued as soon as tx_rdy rises -> frames back-to-back, no idle cycle; a third tx_start while tx_rdy=0 -> ignored.
REQ-033 reset=0 during data bit 3 -> tx=1 next cycle, tx_rdy=1, tx_busy=0, pending byte never sent.
